// File: rtl/csr_access_ctrl_pkg.sv
// csr_access_ctrl_pkg: CSR addresses, trap causes, op encodings and sequencer states
// shared by the CSR access controller and its ALU.
package csr_access_ctrl_pkg;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

   localparam logic [2:0] F3_RW  = 3'b001;
   localparam logic [2:0] F3_RS  = 3'b010;
   localparam logic [2:0] F3_RC  = 3'b011;
   localparam logic [2:0] F3_RWI = 3'b101;
   localparam logic [2:0] F3_RSI = 3'b110;
   localparam logic [2:0] F3_RCI = 3'b111;

   typedef enum logic [2:0] {
      IDLE, READ, WRITE, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, RESP
   } state_e;

   typedef enum logic [1:0] {K_CSR, K_TRAP, K_MRET} kind_e;

   // Set/clear forms with a zero source (x0 or uimm 0) are pure reads.
   function automatic logic csr_skips_write(input logic [2:0] funct3, input logic [4:0] rs1_idx);
      return funct3[1] && rs1_idx == 5'd0;
   endfunction
endpackage

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: pipeline request/response and CSR file port of the CSR access controller.
interface csr_access_ctrl_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_funct3;
   logic              req_is_ecall;
   logic              req_is_ebreak;
   logic              req_is_mret;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_rs1_data;
   logic [4:0]        req_rs1_idx;
   logic [4:0]        req_rd_idx;
   logic [XLEN-1:0]   req_pc;
   logic              csr_wr_en;
   logic              csr_ren;
   logic [ADDR_W-1:0] csr_addr;
   logic [XLEN-1:0]   csr_wr_data;
   logic [XLEN-1:0]   csr_rdata;
   logic              rsp_valid;
   logic              rsp_rd_wr_en;
   logic [4:0]        rsp_rd_idx;
   logic [XLEN-1:0]   rsp_rd_data;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              trap_taken;

   modport master (
      output req_valid, req_funct3, req_is_ecall, req_is_ebreak, req_is_mret, req_addr,
             req_rs1_data, req_rs1_idx, req_rd_idx, req_pc, csr_rdata,
      input  req_ready, csr_wr_en, csr_ren, csr_addr, csr_wr_data, rsp_valid, rsp_rd_wr_en,
             rsp_rd_idx, rsp_rd_data, redirect_valid, redirect_pc, trap_taken
   );

   modport slave (
      input  req_valid, req_funct3, req_is_ecall, req_is_ebreak, req_is_mret, req_addr,
             req_rs1_data, req_rs1_idx, req_rd_idx, req_pc, csr_rdata,
      output req_ready, csr_wr_en, csr_ren, csr_addr, csr_wr_data, rsp_valid, rsp_rd_wr_en,
             rsp_rd_idx, rsp_rd_data, redirect_valid, redirect_pc, trap_taken
   );
endinterface

// File: rtl/csr_access_ctrl_alu.sv
// csr_alu: new CSR value for RW/RS/RC (register and immediate forms) and the write-skip flag.
module csr_alu
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] old_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [4:0]      uimm_i,
   output logic [XLEN-1:0] new_o,
   output logic            skip_wr_o
);
   logic [XLEN-1:0] src;

   always_comb begin
      src       = funct3_i[2] ? XLEN'(uimm_i) : rs1_data_i;
      new_o     = (funct3_i[1:0] == F3_RW[1:0]) ? src :
                  (funct3_i[1:0] == F3_RS[1:0]) ? (old_i | src) : (old_i & ~src);
      skip_wr_o = csr_skips_write(funct3_i, uimm_i);
   end
endmodule

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences the machine-mode CSR file port for CSR read-modify-write,
// trap entry (ECALL/EBREAK/illegal) and MRET, returning rd writeback and PC redirect.
module csr_access_ctrl
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input logic              clk,
   input logic              rst,
   csr_access_ctrl_if.slave bus
);
   state_e            state_q, state_d, st;
   kind_e             kind_q, kind_d;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   rs1_data_q, pc_q, old_q, old_d, tgt_q, tgt_d, alu_new;
   logic [4:0]        rs1_idx_q, rd_idx_q;
   logic [3:0]        cause_q, cause_d;
   logic              accept, alu_skip, read_old, bad_op;

   csr_alu #(.XLEN(XLEN)) u_alu (
      .funct3_i   (funct3_q),
      .old_i      (old_q),
      .rs1_data_i (rs1_data_q),
      .uimm_i     (rs1_idx_q),
      .new_o      (alu_new),
      .skip_wr_o  (alu_skip)
   );

   // Illegal: reserved funct3, or an actual write into the read-only CSR space.
   always_comb begin
      bad_op  = bus.req_funct3[1:0] == 2'b00 ||
                (bus.req_addr[ADDR_W-1 -: 2] == 2'b11 &&
                 !csr_skips_write(bus.req_funct3, bus.req_rs1_idx));
      kind_d  = (bus.req_is_ecall || bus.req_is_ebreak) ? K_TRAP :
                bus.req_is_mret ? K_MRET : bad_op ? K_TRAP : K_CSR;
      cause_d = bus.req_is_ecall ? CAUSE_ECALL_M :
                bus.req_is_ebreak ? CAUSE_BREAKPOINT : CAUSE_ILLEGAL;
      accept  = bus.req_valid && state_q == IDLE && !rst;
   end

   // Outputs are forced idle while rst is high so an abandoned sequence never writes.
   always_comb begin
      st                 = rst ? IDLE : state_q;
      state_d            = state_q;
      old_d              = old_q;
      tgt_d              = tgt_q;
      read_old           = rd_idx_q != 5'd0 || funct3_q[1];
      bus.req_ready      = 1'b0;
      bus.csr_wr_en      = 1'b0;
      bus.csr_ren        = 1'b0;
      bus.csr_addr       = '0;
      bus.csr_wr_data    = '0;
      bus.rsp_valid      = 1'b0;
      bus.rsp_rd_wr_en   = 1'b0;
      bus.rsp_rd_idx     = '0;
      bus.rsp_rd_data    = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.trap_taken     = 1'b0;
      unique case (st)
         IDLE: begin
            bus.req_ready = 1'b1;
            state_d       = !accept ? IDLE : kind_d == K_TRAP ? TRAP_EPC :
                            kind_d == K_MRET ? MRET_RD : READ;
         end
         READ: begin
            bus.csr_ren  = read_old;
            bus.csr_addr = read_old ? addr_q : '0;
            old_d        = read_old ? bus.csr_rdata : '0;
            state_d      = WRITE;
         end
         WRITE: begin
            bus.csr_wr_en   = !alu_skip;
            bus.csr_addr    = alu_skip ? '0 : addr_q;
            bus.csr_wr_data = alu_skip ? '0 : alu_new;
            state_d         = RESP;
         end
         TRAP_EPC: begin
            bus.csr_wr_en   = 1'b1;
            bus.csr_addr    = ADDR_W'(CSR_MEPC);
            bus.csr_wr_data = pc_q;
            state_d         = TRAP_CAUSE;
         end
         TRAP_CAUSE: begin
            bus.csr_wr_en   = 1'b1;
            bus.csr_addr    = ADDR_W'(CSR_MCAUSE);
            bus.csr_wr_data = XLEN'(cause_q);
            state_d         = TRAP_VEC;
         end
         TRAP_VEC: begin
            bus.csr_ren  = 1'b1;
            bus.csr_addr = ADDR_W'(CSR_MTVEC);
            tgt_d        = {bus.csr_rdata[XLEN-1:2], 2'b00};
            state_d      = RESP;
         end
         MRET_RD: begin
            bus.csr_ren  = 1'b1;
            bus.csr_addr = ADDR_W'(CSR_MEPC);
            tgt_d        = {bus.csr_rdata[XLEN-1:1], 1'b0};
            state_d      = RESP;
         end
         RESP: begin
            bus.rsp_valid      = 1'b1;
            bus.rsp_rd_wr_en   = kind_q == K_CSR && rd_idx_q != 5'd0;
            bus.rsp_rd_idx     = rd_idx_q;
            bus.rsp_rd_data    = kind_q == K_CSR ? old_q : '0;
            bus.redirect_valid = kind_q != K_CSR;
            bus.redirect_pc    = kind_q != K_CSR ? tgt_q : '0;
            bus.trap_taken     = kind_q == K_TRAP;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         kind_q     <= K_CSR;
         cause_q    <= '0;
         funct3_q   <= '0;
         addr_q     <= '0;
         rs1_data_q <= '0;
         rs1_idx_q  <= '0;
         rd_idx_q   <= '0;
         pc_q       <= '0;
         old_q      <= '0;
         tgt_q      <= '0;
      end else begin
         state_q <= state_d;
         old_q   <= old_d;
         tgt_q   <= tgt_d;
         if (accept) begin
            kind_q     <= kind_d;
            cause_q    <= cause_d;
            funct3_q   <= bus.req_funct3;
            addr_q     <= bus.req_addr;
            rs1_data_q <= bus.req_rs1_data;
            rs1_idx_q  <= bus.req_rs1_idx;
            rd_idx_q   <= bus.req_rd_idx;
            pc_q       <= bus.req_pc;
         end
      end
   end
endmodule
